key_unlock_loader: RTL

- Provisions the 32-bit activation key to an XOR/XNOR-locked datapath block (e.g. the locked 16-bit carry-lookahead adder); it sits on the key-input side of that block's `keyinput` bus.
- Accepts the key serially from the secure key store and presents it to the locked block.
- Self-checks the key by driving a fixed test vector through the locked adder and comparing the result against a golden sum.
- Asserts unlocked only on a match; counts failed attempts and locks out permanently (until reset) after MAX_FAIL failures.

---
 rtl/key_unlock_pkg.sv | 27 ++
 rtl/key_shift_in.sv | 48 ++++
 rtl/key_unlock_loader.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/key_unlock_pkg.sv
// Shared types and constants for the key unlock loader.
// Holds the FSM state encoding and the golden-sum helper used by the self-check.
package key_unlock_pkg;

    localparam int DEF_KEY_W  = 32;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_FAIL_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        CHECK,
        UNLOCKED,
        LOCKOUT
    } state_e;

    // The carry-out is part of the golden value, so a key that only breaks
    // the top carry stage is still rejected.
    function automatic logic [DEF_DATA_W:0] golden_sum(
        input logic [DEF_DATA_W-1:0] a,
        input logic [DEF_DATA_W-1:0] b
    );
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/key_shift_in.sv
// Serial key shadow register with bit counter; bits arrive LSB first.
// Clear has priority over accept, so a restart discards a same-cycle bit.
module key_shift_in
    import key_unlock_pkg::*;
#(
    parameter int KEY_W = DEF_KEY_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             accept_i,
    input  logic             key_bit_i,
    output logic [KEY_W-1:0] shadow_next_o,
    output logic             done_o
);

    localparam int CNT_W = $clog2(KEY_W);

    logic [KEY_W-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

    always_comb begin
        shadow_d  = shadow_q;
        bit_cnt_d = bit_cnt_q;
        done_o    = 1'b0;
        if (clear_i) begin
            shadow_d  = '0;
            bit_cnt_d = '0;
        end else if (accept_i) begin
            shadow_d[bit_cnt_q] = key_bit_i;
            bit_cnt_d           = bit_cnt_q + 1'b1;
            done_o              = (bit_cnt_q == CNT_W'(KEY_W - 1));
        end
        // Next value lets the top capture the full key on the last-bit edge.
        shadow_next_o = shadow_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shadow_q  <= '0;
            bit_cnt_q <= '0;
        end else begin
            shadow_q  <= shadow_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/key_unlock_loader.sv
// Loads the activation key into a locked adder and self-checks it against a golden sum.
//   state    | meaning
//   IDLE     | waiting for start_i, key bus zero
//   LOAD     | shifting key bits in from the key store
//   SETTLE   | key and test vector applied, waiting for the adder to settle
//   CHECK    | sample result_i and compare with the golden sum
//   UNLOCKED | key verified and held on keyinput_o
//   LOCKOUT  | too many failures, frozen until reset
module key_unlock_loader
    import key_unlock_pkg::*;
#(
    parameter int                 KEY_W      = DEF_KEY_W,
    parameter int                 DATA_W     = DEF_DATA_W,
    parameter logic [DATA_W-1:0]  TEST_A     = 16'hA5C3,
    parameter logic [DATA_W-1:0]  TEST_B     = 16'h7E29,
    parameter int                 SETTLE_CYC = 2,
    parameter int                 MAX_FAIL   = 3,
    parameter int                 FAIL_W     = DEF_FAIL_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              key_bit_i,
    input  logic              key_valid_i,
    output logic              key_ready_o,
    output logic [KEY_W-1:0]  keyinput_o,
    output logic              tst_sel_o,
    output logic [DATA_W-1:0] tst_add1_o,
    output logic [DATA_W-1:0] tst_add2_o,
    input  logic [DATA_W:0]   result_i,
    output logic              unlocked_o,
    output logic              lockout_o,
    output logic [FAIL_W-1:0] fail_cnt_o
);

    localparam logic [DATA_W:0] GOLDEN = golden_sum(TEST_A, TEST_B);

    state_e            state_q, state_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic [3:0]        settle_q, settle_d;
    logic [FAIL_W-1:0] fail_q, fail_d, fail_inc;
    logic              key_ready_q, tst_sel_q, unlocked_q, lockout_q;
    logic              clear, accept, done;
    logic [KEY_W-1:0]  shadow_next;

    key_shift_in #(.KEY_W(KEY_W)) u_shift (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .clear_i       (clear),
        .accept_i      (accept),
        .key_bit_i     (key_bit_i),
        .shadow_next_o (shadow_next),
        .done_o        (done)
    );

    // Saturating increment; never wraps back to zero.
    assign fail_inc = (&fail_q) ? fail_q : fail_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        settle_d = settle_q;
        fail_d   = fail_q;
        clear    = 1'b0;
        accept   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = LOAD;
                    clear   = 1'b1;
                end
            end
            LOAD: begin
                if (start_i) begin
                    clear = 1'b1;
                end else if (key_valid_i) begin
                    accept = 1'b1;
                    if (done) begin
                        key_d    = shadow_next;
                        state_d  = SETTLE;
                        settle_d = '0;
                    end
                end
            end
            SETTLE: begin
                if (settle_q == 4'(SETTLE_CYC - 1)) state_d = CHECK;
                else                                settle_d = settle_q + 1'b1;
            end
            CHECK: begin
                if (result_i == GOLDEN) begin
                    state_d = UNLOCKED;
                    fail_d  = '0;
                end else begin
                    key_d   = '0;
                    fail_d  = fail_inc;
                    state_d = (fail_inc >= FAIL_W'(MAX_FAIL)) ? LOCKOUT : IDLE;
                end
            end
            UNLOCKED: begin
                if (start_i) begin
                    key_d   = '0;
                    state_d = LOAD;
                    clear   = 1'b1;
                end
            end
            LOCKOUT: key_d = '0;
            default: begin
                state_d = IDLE;
                key_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            key_q       <= '0;
            settle_q    <= '0;
            fail_q      <= '0;
            key_ready_q <= 1'b0;
            tst_sel_q   <= 1'b0;
            unlocked_q  <= 1'b0;
            lockout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            settle_q    <= settle_d;
            fail_q      <= fail_d;
            key_ready_q <= (state_d == LOAD);
            tst_sel_q   <= (state_d == SETTLE) || (state_d == CHECK);
            unlocked_q  <= (state_d == UNLOCKED);
            lockout_q   <= (state_d == LOCKOUT);
        end
    end

    assign keyinput_o  = key_q;
    assign key_ready_o = key_ready_q;
    assign tst_sel_o   = tst_sel_q;
    assign unlocked_o  = unlocked_q;
    assign lockout_o   = lockout_q;
    assign fail_cnt_o  = fail_q;
    assign tst_add1_o  = TEST_A;
    assign tst_add2_o  = TEST_B;

endmodule
